// File: rtl/spi_lcd_pkg.sv
// Shared opcodes, widths and decoder state encoding for the SPI LCD receiver.
package spi_lcd_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [BYTE_W-1:0] CMD_SLPIN   = 8'h10;
  localparam logic [BYTE_W-1:0] CMD_SLPOUT  = 8'h11;
  localparam logic [BYTE_W-1:0] CMD_DISPOFF = 8'h28;
  localparam logic [BYTE_W-1:0] CMD_DISPON  = 8'h29;
  localparam logic [BYTE_W-1:0] CMD_COLMOD  = 8'h3A;
  localparam logic [BYTE_W-1:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {
    D_IDLE       = 2'd0,
    D_COLMOD_ARG = 2'd1,
    D_RAM_HI     = 2'd2,
    D_RAM_LO     = 2'd3
  } dec_state_e;

endpackage

// File: rtl/spi_rx_shift.sv
// Synchronises the raw SPI pins into clk and assembles MSB-first bytes tagged
// with the dc level seen on the final bit.
module spi_rx_shift
  import spi_lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_i,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic              dc_i,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              rx_dc_o,
  output logic              rx_valid_o,
  output logic              cs_sync_o
);

  // Pin order inside each synchroniser stage: {cs, scl, sda, dc}; cs idles high.
  localparam logic [3:0] PINS_IDLE = 4'b1000;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic                        scl_prev_q, scl_prev_d;
  logic [BYTE_W-2:0]           shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]           rx_byte_q, rx_byte_d;
  logic                        rx_dc_q, rx_dc_d;
  logic                        rx_valid_q, rx_valid_d;

  logic cs_s, scl_s, sda_s, dc_s, scl_rise;

  assign {cs_s, scl_s, sda_s, dc_s} = sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], {cs_i, scl_i, sda_i, dc_i}};
    scl_prev_d = scl_s;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    rx_byte_d  = rx_byte_q;
    rx_dc_d    = rx_dc_q;
    rx_valid_d = 1'b0;

    // A deselected bus drops any partial byte without reporting it.
    if (cs_s) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (scl_rise) begin
      shreg_d = {shreg_q[BYTE_W-3:0], sda_s};
      if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
        rx_byte_d  = {shreg_q, sda_s};
        rx_dc_d    = dc_s;
        rx_valid_d = 1'b1;
        bit_cnt_d  = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{PINS_IDLE}};
      scl_prev_q <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      rx_byte_q  <= '0;
      rx_dc_q    <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      scl_prev_q <= scl_prev_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_byte_q  <= rx_byte_d;
      rx_dc_q    <= rx_dc_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_byte_o  = rx_byte_q;
  assign rx_dc_o    = rx_dc_q;
  assign rx_valid_o = rx_valid_q;
  assign cs_sync_o  = cs_s;

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI mode-0 LCD receiver: byte capture plus ST7789-style command decode and
// RGB565 pixel pairing during memory write.
module spi_lcd_rx
  import spi_lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PIX_CNT_W   = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 scl,
  input  logic                 sda,
  input  logic                 dc,
  output logic [BYTE_W-1:0]    rx_byte,
  output logic                 rx_dc,
  output logic                 rx_valid,
  output logic                 awake,
  output logic                 disp_on,
  output logic [BYTE_W-1:0]    colmod,
  output logic                 ram_wr,
  output logic [2*BYTE_W-1:0]  pixel,
  output logic                 pixel_valid,
  output logic [PIX_CNT_W-1:0] pixel_cnt,
  output logic                 cmd_err,
  output logic                 data_err
);

  logic [BYTE_W-1:0] rx_byte_w;
  logic              rx_dc_w, rx_valid_w, cs_sync_w;

  spi_rx_shift #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .cs_i       (cs),
    .scl_i      (scl),
    .sda_i      (sda),
    .dc_i       (dc),
    .rx_byte_o  (rx_byte_w),
    .rx_dc_o    (rx_dc_w),
    .rx_valid_o (rx_valid_w),
    .cs_sync_o  (cs_sync_w)
  );

  dec_state_e          state_q, state_d;
  logic                awake_q, awake_d;
  logic                disp_on_q, disp_on_d;
  logic [BYTE_W-1:0]   colmod_q, colmod_d;
  logic                ram_wr_q, ram_wr_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [2*BYTE_W-1:0] pixel_q, pixel_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [PIX_CNT_W-1:0] pixel_cnt_q, pixel_cnt_d;
  logic                cmd_err_q, cmd_err_d;
  logic                data_err_q, data_err_d;

  always_comb begin
    state_d       = state_q;
    awake_d       = awake_q;
    disp_on_d     = disp_on_q;
    colmod_d      = colmod_q;
    ram_wr_d      = ram_wr_q;
    hi_d          = hi_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    pixel_cnt_d   = pixel_cnt_q;
    cmd_err_d     = 1'b0;
    data_err_d    = 1'b0;

    if (rx_valid_w && !rx_dc_w) begin
      // Commands are honoured from any state and abort pending arguments.
      state_d  = D_IDLE;
      ram_wr_d = 1'b0;
      case (rx_byte_w)
        CMD_SLPOUT:  awake_d   = 1'b1;
        CMD_SLPIN:   awake_d   = 1'b0;
        CMD_DISPON:  disp_on_d = 1'b1;
        CMD_DISPOFF: disp_on_d = 1'b0;
        CMD_COLMOD:  state_d   = D_COLMOD_ARG;
        CMD_RAMWR: begin
          ram_wr_d    = 1'b1;
          pixel_cnt_d = '0;
          state_d     = D_RAM_HI;
        end
        default:     cmd_err_d = 1'b1;
      endcase
    end else if (rx_valid_w) begin
      case (state_q)
        D_COLMOD_ARG: begin
          colmod_d = rx_byte_w;
          state_d  = D_IDLE;
        end
        D_RAM_HI: begin
          hi_d    = rx_byte_w;
          state_d = D_RAM_LO;
        end
        D_RAM_LO: begin
          pixel_d       = {hi_q, rx_byte_w};
          pixel_valid_d = 1'b1;
          if (pixel_cnt_q != {PIX_CNT_W{1'b1}}) begin
            pixel_cnt_d = pixel_cnt_q + PIX_CNT_W'(1);
          end
          state_d = D_RAM_HI;
        end
        default: data_err_d = 1'b1;
      endcase
    end else if (cs_sync_w && state_q == D_RAM_LO) begin
      // Frame ended between the two bytes of a pixel: drop the high byte.
      state_d = D_RAM_HI;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= D_IDLE;
      awake_q       <= 1'b0;
      disp_on_q     <= 1'b0;
      colmod_q      <= '0;
      ram_wr_q      <= 1'b0;
      hi_q          <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_cnt_q   <= '0;
      cmd_err_q     <= 1'b0;
      data_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      awake_q       <= awake_d;
      disp_on_q     <= disp_on_d;
      colmod_q      <= colmod_d;
      ram_wr_q      <= ram_wr_d;
      hi_q          <= hi_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_cnt_q   <= pixel_cnt_d;
      cmd_err_q     <= cmd_err_d;
      data_err_q    <= data_err_d;
    end
  end

  assign rx_byte     = rx_byte_w;
  assign rx_dc       = rx_dc_w;
  assign rx_valid    = rx_valid_w;
  assign awake       = awake_q;
  assign disp_on     = disp_on_q;
  assign colmod      = colmod_q;
  assign ram_wr      = ram_wr_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_cnt   = pixel_cnt_q;
  assign cmd_err     = cmd_err_q;
  assign data_err    = data_err_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: drives SPI frames and checks decoded state.
module tb_spi_lcd_rx;

  localparam int HALF = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1, scl = 1'b0, sda = 1'b0, dc = 1'b0;
  logic [7:0]  rx_byte, colmod;
  logic        rx_dc, rx_valid, awake, disp_on, ram_wr, pixel_valid, cmd_err, data_err;
  logic [15:0] pixel;
  logic [16:0] pixel_cnt;

  spi_lcd_rx dut (
    .clk(clk), .reset(reset), .cs(cs), .scl(scl), .sda(sda), .dc(dc),
    .rx_byte(rx_byte), .rx_dc(rx_dc), .rx_valid(rx_valid),
    .awake(awake), .disp_on(disp_on), .colmod(colmod), .ram_wr(ram_wr),
    .pixel(pixel), .pixel_valid(pixel_valid), .pixel_cnt(pixel_cnt),
    .cmd_err(cmd_err), .data_err(data_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: totals only ever increase; the stimulus process takes deltas.
  int rx_tot = 0, pix_tot = 0, cerr_tot = 0, derr_tot = 0;
  logic [15:0] px_log [0:15];
  always @(negedge clk) begin
    if (rx_valid) rx_tot++;
    if (cmd_err)  cerr_tot++;
    if (data_err) derr_tot++;
    if (pixel_valid) begin
      px_log[pix_tot % 16] = pixel;
      pix_tot++;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sda = b[7-i];
      dc  = d;
      wait_clk(HALF);
      scl = 1'b1;
      wait_clk(HALF);
      scl = 1'b0;
    end
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_hi();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic frame1(input logic [7:0] b, input logic d);
    cs_lo();
    spi_bits(b, d, 8);
    cs_hi();
  endtask

  task automatic frame2(input logic [7:0] b0, input logic [7:0] b1, input logic d);
    cs_lo();
    spi_bits(b0, d, 8);
    spi_bits(b1, d, 8);
    cs_hi();
  endtask

  int rx0, pix0, ce0, de0;

  task automatic snap();
    rx0 = rx_tot; pix0 = pix_tot; ce0 = cerr_tot; de0 = derr_tot;
  endtask

  initial begin
    wait_clk(4);
    check("rst_rx_byte", 32'(rx_byte), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_awake", 32'(awake), 32'h0);
    check("rst_colmod", 32'(colmod), 32'h0);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    check("rst_pixel_cnt", 32'(pixel_cnt), 32'h0);
    reset = 1'b0;
    wait_clk(4);

    // Init sequence in a single frame.
    snap();
    cs_lo();
    spi_bits(8'h11, 1'b0, 8);
    spi_bits(8'h29, 1'b0, 8);
    spi_bits(8'h3A, 1'b0, 8);
    spi_bits(8'h55, 1'b1, 8);
    spi_bits(8'h2C, 1'b0, 8);
    cs_hi();
    check("init_rx_count", 32'(rx_tot - rx0), 32'd5);
    check("init_awake", 32'(awake), 32'h1);
    check("init_disp_on", 32'(disp_on), 32'h1);
    check("init_colmod", 32'(colmod), 32'h55);
    check("init_ram_wr", 32'(ram_wr), 32'h1);
    check("init_pixel_cnt", 32'(pixel_cnt), 32'h0);
    check("init_cmd_err", 32'(cerr_tot - ce0), 32'd0);
    check("init_data_err", 32'(derr_tot - de0), 32'd0);

    // Three pixels, each in its own frame.
    snap();
    frame2(8'hF8, 8'h00, 1'b1);
    frame2(8'h07, 8'hE0, 1'b1);
    frame2(8'h00, 8'h1F, 1'b1);
    check("pix_count", 32'(pix_tot - pix0), 32'd3);
    check("pix0", 32'(px_log[pix0 % 16]), 32'hF800);
    check("pix1", 32'(px_log[(pix0 + 1) % 16]), 32'h07E0);
    check("pix2", 32'(px_log[(pix0 + 2) % 16]), 32'h001F);
    check("pix_cnt3", 32'(pixel_cnt), 32'd3);
    check("pix_ram_wr", 32'(ram_wr), 32'h1);

    // Half pixel dropped by cs rising.
    snap();
    frame1(8'hAB, 1'b1);
    frame2(8'h12, 8'h34, 1'b1);
    check("half_pix_count", 32'(pix_tot - pix0), 32'd1);
    check("half_pix_value", 32'(pixel), 32'h1234);
    check("half_pix_cnt", 32'(pixel_cnt), 32'd4);
    check("half_data_err", 32'(derr_tot - de0), 32'd0);

    // Partial byte discarded, then a clean command.
    frame1(8'h28, 1'b0);
    check("dispoff", 32'(disp_on), 32'h0);
    check("dispoff_ram_wr", 32'(ram_wr), 32'h0);
    snap();
    cs_lo();
    spi_bits(8'hA5, 1'b0, 5);
    cs_hi();
    check("partial_no_rx", 32'(rx_tot - rx0), 32'd0);
    frame1(8'h29, 1'b0);
    check("partial_rx_count", 32'(rx_tot - rx0), 32'd1);
    check("partial_rx_byte", 32'(rx_byte), 32'h29);
    check("partial_rx_dc", 32'(rx_dc), 32'h0);
    check("partial_disp_on", 32'(disp_on), 32'h1);

    // Unsupported command, then an orphan data byte.
    frame1(8'h2C, 1'b0);
    check("ramwr_again", 32'(ram_wr), 32'h1);
    snap();
    frame1(8'h99, 1'b0);
    check("bad_cmd_err", 32'(cerr_tot - ce0), 32'd1);
    check("bad_cmd_ram_wr", 32'(ram_wr), 32'h0);
    frame1(8'h66, 1'b1);
    check("orphan_data_err", 32'(derr_tot - de0), 32'd1);
    check("orphan_colmod", 32'(colmod), 32'h55);
    check("orphan_no_pixel", 32'(pix_tot - pix0), 32'd0);

    // Asynchronous reset in the middle of a pixel byte.
    frame1(8'h2C, 1'b0);
    cs_lo();
    spi_bits(8'h12, 1'b1, 1);
    sda = 1'b0;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(4);
    #2 reset = 1'b1;
    #1;
    check("arst_awake", 32'(awake), 32'h0);
    check("arst_disp_on", 32'(disp_on), 32'h0);
    check("arst_colmod", 32'(colmod), 32'h0);
    check("arst_ram_wr", 32'(ram_wr), 32'h0);
    check("arst_pixel", 32'(pixel), 32'h0);
    check("arst_rx_byte", 32'(rx_byte), 32'h0);
    scl = 1'b0;
    cs  = 1'b1;
    wait_clk(5);
    snap();
    reset = 1'b0;
    wait_clk(10);
    check("release_no_rx", 32'(rx_tot - rx0), 32'd0);
    check("release_no_err", 32'((cerr_tot - ce0) + (derr_tot - de0)), 32'd0);
    frame1(8'h11, 1'b0);
    check("post_rst_awake", 32'(awake), 32'h1);
    check("post_rst_rx_byte", 32'(rx_byte), 32'h11);
    check("post_rst_pixel_cnt", 32'(pixel_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
